cam_capture_window: RTL and testbench

Parametrised pixel capture engine on the camera pixel clock. It converts the camera's byte stream (VSYNC/HREF/8-bit data) into pixel words and writes them to a downstream FIFO. It supports selectable pixel formats, a runtime crop window, power-of-two decimation and frame-granular overflow handling with status counters. It replaces the fixed RGB444 capture stage in front of the camera output FIFO.

---
 rtl/cam_pkg.sv | 44 ++++
 rtl/cam_pix_pack.sv | 51 +++++
 rtl/cam_capture_window.sv | 216 +++++++++++++++++++++
 tb/tb_cam_capture_window.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path.
// Holds the pixel-format encodings, the capture FSM state encoding and the
// helpers that decide when a byte completes a pixel and how the pixel word
// is packed.
package cam_pkg;

  localparam logic [1:0] MODE_RGB444 = 2'd0;
  localparam logic [1:0] MODE_RGB565 = 2'd1;
  localparam logic [1:0] MODE_Y      = 2'd2;
  localparam logic [1:0] MODE_RAW    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_DROP     = 2'd3
  } cam_state_e;

  // True when the byte sampled at the given phase finishes a pixel.
  function automatic logic pix_completes(input logic [1:0] mode, input logic phase);
    logic done;
    case (mode)
      MODE_RGB444, MODE_RGB565: done = phase;
      MODE_Y:                   done = ~phase;
      default:                  done = 1'b1;
    endcase
    return done;
  endfunction

  // first_byte is the held even byte; cur_byte is the byte being sampled.
  // For Y and raw modes the current byte is the whole pixel.
  function automatic logic [15:0] pack_pixel(input logic [1:0] mode,
                                             input logic [7:0] first_byte,
                                             input logic [7:0] cur_byte);
    logic [15:0] word;
    case (mode)
      MODE_RGB444: word = {4'h0, first_byte[3:0], cur_byte};
      MODE_RGB565: word = {first_byte, cur_byte};
      default:     word = {8'h00, cur_byte};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/cam_pix_pack.sv
// Byte-to-pixel assembler.
// Tracks the byte phase within a row, holds the first byte of a two-byte
// pixel and produces the packed pixel word in the same cycle as the byte
// that completes it.
// Ports:
//   i_pclk, i_rstn   pixel clock, async active-low reset
//   i_href           row byte valid
//   i_href_rise      href rising edge (from the registered href in the top)
//   i_clr            frame start; discards any half-assembled pixel
//   i_mode           pixel format (latched at SOF by the top)
//   i_data           camera byte
//   pix_valid        this cycle's byte completes a pixel
//   pix_data         packed pixel word, meaningful when pix_valid=1
module cam_pix_pack
  import cam_pkg::*;
(
  input  logic        i_pclk,
  input  logic        i_rstn,
  input  logic        i_href,
  input  logic        i_href_rise,
  input  logic        i_clr,
  input  logic [1:0]  i_mode,
  input  logic [7:0]  i_data,
  output logic        pix_valid,
  output logic [15:0] pix_data
);

  logic       phase_q;
  logic [7:0] first_q;
  logic       phase;

  // The first byte of a row is always phase 0, regardless of where the
  // previous row left the phase.
  assign phase = i_href_rise ? 1'b0 : phase_q;

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      phase_q <= 1'b0;
      first_q <= 8'h00;
    end else if (i_clr) begin
      phase_q <= 1'b0;
    end else if (i_href) begin
      phase_q <= ~phase;
      if (!phase) first_q <= i_data;
    end
  end

  assign pix_valid = i_href & pix_completes(i_mode, phase);
  assign pix_data  = pack_pixel(i_mode, first_q, i_data);

endmodule

// File: rtl/cam_capture_window.sv
// Camera capture engine: turns the VSYNC/HREF/byte stream into pixel words
// for the downstream FIFO, with selectable pixel format, crop window,
// power-of-two decimation and frame-granular overflow handling.
// Ports:
//   i_pclk, i_rstn         pixel clock, async active-low reset
//   i_cfg_done             capture enable
//   i_vsync, i_href, i_data  camera interface
//   i_mode, i_x0..i_y1, i_decim  runtime config, latched at each SOF
//   i_full                 downstream almost-full
//   i_ovf_clr              clears the sticky overflow flag
//   o_wr, o_wdata          registered FIFO write
//   o_sof                  start-of-frame pulse
//   o_ovf                  sticky overflow
//   o_frame_cnt            frames delivered intact
//   o_drop_cnt             frames truncated by overflow
//   o_busy                 capturing or dropping a frame
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | capture disabled
// WAIT_SOF  | enabled, waiting for the first vsync rising edge
// ACTIVE    | inside a frame, writing kept pixels
// DROP      | frame hit overflow, discarding until next vsync
module cam_capture_window
  import cam_pkg::*;
#(
  parameter int X_W    = 11,
  parameter int Y_W    = 10,
  parameter int FCNT_W = 16
) (
  input  logic              i_pclk,
  input  logic              i_rstn,
  input  logic              i_cfg_done,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_data,
  input  logic [1:0]        i_mode,
  input  logic [X_W-1:0]    i_x0,
  input  logic [X_W-1:0]    i_x1,
  input  logic [Y_W-1:0]    i_y0,
  input  logic [Y_W-1:0]    i_y1,
  input  logic [1:0]        i_decim,
  input  logic              i_full,
  input  logic              i_ovf_clr,
  output logic              o_wr,
  output logic [15:0]       o_wdata,
  output logic              o_sof,
  output logic              o_ovf,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic [FCNT_W-1:0] o_drop_cnt,
  output logic              o_busy
);

  cam_state_e state_q, state_d;

  logic             vsync_q, href_q;
  logic             vsync_rise, href_rise, href_fall;

  logic [1:0]       mode_q;
  logic [X_W-1:0]   x0_q, x1_q;
  logic [Y_W-1:0]   y0_q, y1_q;
  logic [1:0]       decim_q;

  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;

  logic             pix_valid;
  logic [15:0]      pix_data;
  logic [2:0]       dmask;
  logic             keep;

  logic             start_frame, do_write, set_ovf, inc_frame, inc_drop;

  assign vsync_rise = i_vsync & ~vsync_q;
  assign href_rise  = i_href & ~href_q;
  assign href_fall  = ~i_href & href_q;

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= i_vsync;
      href_q  <= i_href;
    end
  end

  // Phase is cleared on every vsync rise so a pixel cut by a new frame
  // never pairs with a byte of the next frame.
  cam_pix_pack u_pack (
    .i_pclk      (i_pclk),
    .i_rstn      (i_rstn),
    .i_href      (i_href),
    .i_href_rise (href_rise),
    .i_clr       (vsync_rise),
    .i_mode      (mode_q),
    .i_data      (i_data),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data)
  );

  // Window and decimation test on the column/line of the completing pixel.
  // An inverted window simply never matches.
  assign dmask = 3'((4'd1 << decim_q) - 4'd1);
  assign keep  = (x_q >= x0_q) && (x_q <= x1_q) &&
                 (y_q >= y0_q) && (y_q <= y1_q) &&
                 ((x_q[2:0] & dmask) == 3'd0) &&
                 ((y_q[2:0] & dmask) == 3'd0);

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    do_write    = 1'b0;
    set_ovf     = 1'b0;
    inc_frame   = 1'b0;
    inc_drop    = 1'b0;
    if (!i_cfg_done) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_SOF;
        ST_WAIT_SOF: begin
          if (vsync_rise) begin
            start_frame = 1'b1;
            state_d     = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (vsync_rise) begin
            inc_frame   = 1'b1;
            start_frame = 1'b1;
          end else if (pix_valid && keep) begin
            if (i_full) begin
              set_ovf = 1'b1;
              state_d = ST_DROP;
            end else begin
              do_write = 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (vsync_rise) begin
            inc_drop    = 1'b1;
            start_frame = 1'b1;
            state_d     = ST_ACTIVE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Config is only sampled at frame start so mid-frame edits cannot tear
  // the window.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      mode_q  <= MODE_RGB444;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      decim_q <= 2'd0;
    end else if (start_frame) begin
      mode_q  <= i_mode;
      x0_q    <= i_x0;
      x1_q    <= i_x1;
      y0_q    <= i_y0;
      y1_q    <= i_y1;
      decim_q <= i_decim;
    end
  end

  // Column/line position; href fall and pixel completion are exclusive
  // since a pixel needs href high.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_q <= '0;
      y_q <= '0;
    end else if (start_frame) begin
      x_q <= '0;
      y_q <= '0;
    end else if (href_fall) begin
      x_q <= '0;
      if (y_q != '1) y_q <= y_q + Y_W'(1);
    end else if (pix_valid && (x_q != '1)) begin
      x_q <= x_q + X_W'(1);
    end
  end

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_wr        <= 1'b0;
      o_wdata     <= 16'h0000;
      o_sof       <= 1'b0;
      o_ovf       <= 1'b0;
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      o_wr  <= do_write;
      o_sof <= start_frame;
      if (do_write) o_wdata <= pix_data;
      if (set_ovf)        o_ovf <= 1'b1;
      else if (i_ovf_clr) o_ovf <= 1'b0;
      if (inc_frame && (o_frame_cnt != '1)) o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
      if (inc_drop && (o_drop_cnt != '1))   o_drop_cnt  <= o_drop_cnt + FCNT_W'(1);
    end
  end

  assign o_busy = (state_q == ST_ACTIVE) || (state_q == ST_DROP);

endmodule

// File: tb/tb_cam_capture_window.sv
module tb_cam_capture_window;
  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int FCNT_W = 16;

  logic              i_pclk = 1'b0;
  logic              i_rstn = 1'b1;
  logic              i_cfg_done = 1'b0;
  logic              i_vsync = 1'b0;
  logic              i_href = 1'b0;
  logic [7:0]        i_data = 8'h00;
  logic [1:0]        i_mode = 2'd0;
  logic [X_W-1:0]    i_x0 = '0;
  logic [X_W-1:0]    i_x1 = '0;
  logic [Y_W-1:0]    i_y0 = '0;
  logic [Y_W-1:0]    i_y1 = '0;
  logic [1:0]        i_decim = 2'd0;
  logic              i_full = 1'b0;
  logic              i_ovf_clr = 1'b0;
  logic              o_wr;
  logic [15:0]       o_wdata;
  logic              o_sof;
  logic              o_ovf;
  logic [FCNT_W-1:0] o_frame_cnt;
  logic [FCNT_W-1:0] o_drop_cnt;
  logic              o_busy;

  always #5 i_pclk = ~i_pclk;

  cam_capture_window #(.X_W(X_W), .Y_W(Y_W), .FCNT_W(FCNT_W)) dut (
    .i_pclk      (i_pclk),
    .i_rstn      (i_rstn),
    .i_cfg_done  (i_cfg_done),
    .i_vsync     (i_vsync),
    .i_href      (i_href),
    .i_data      (i_data),
    .i_mode      (i_mode),
    .i_x0        (i_x0),
    .i_x1        (i_x1),
    .i_y0        (i_y0),
    .i_y1        (i_y1),
    .i_decim     (i_decim),
    .i_full      (i_full),
    .i_ovf_clr   (i_ovf_clr),
    .o_wr        (o_wr),
    .o_wdata     (o_wdata),
    .o_sof       (o_sof),
    .o_ovf       (o_ovf),
    .o_frame_cnt (o_frame_cnt),
    .o_drop_cnt  (o_drop_cnt),
    .o_busy      (o_busy)
  );

  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;

  int cur_mode, cx0, cx1, cy0, cy1, cd;
  int full_at = 0;
  int kept_n = 0;
  bit dropped = 0;

  function automatic logic [7:0] bval(input int y, input int i);
    int v;
    v = y * 29 + i * 7 + 53;
    return v[7:0];
  endfunction

  function automatic bit in_window(input int x, input int y);
    int step;
    step = 1 << cd;
    return (x >= cx0) && (x <= cx1) && (y >= cy0) && (y <= cy1) &&
           ((x % step) == 0) && ((y % step) == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every DUT write pops one expected word.
  always @(negedge i_pclk) begin
    if (o_wr === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got write %0h expected no write", o_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (o_wdata !== e) begin
          bad++;
          $display("FAIL wdata: got %0h expected %0h", o_wdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_pclk);
    #2;
  endtask

  // Drives one row; model_on=0 means no write may result. rst_at>=0 asserts
  // reset just before byte rst_at would be driven.
  task automatic send_line(input int y, input int npx, input bit model_on, input int rst_at);
    int bpp, nb, px;
    bit done;
    logic [7:0] b0v, cur;
    bpp = (cur_mode == 3) ? 1 : 2;
    nb  = npx * bpp;
    for (int i = 0; i < nb; i++) begin
      @(posedge i_pclk);
      if (i == rst_at) begin
        @(negedge i_pclk);
        #1;
        i_rstn = 1'b0;
        i_href = 1'b0;
        return;
      end
      #2;
      cur = bval(y, i);
      i_href = 1'b1;
      i_data = cur;
      i_full = 1'b0;
      i_ovf_clr = 1'b0;
      px = i / bpp;
      case (cur_mode)
        0, 1:    done = (i % 2) == 1;
        2:       done = (i % 2) == 0;
        default: done = 1'b1;
      endcase
      if (done && model_on && !dropped && in_window(px, y)) begin
        kept_n++;
        if (kept_n == full_at) begin
          i_full = 1'b1;
          i_ovf_clr = 1'b1;
          dropped = 1'b1;
        end else begin
          b0v = bval(y, px * bpp);
          case (cur_mode)
            0:       exp_q.push_back({4'h0, b0v[3:0], cur});
            1:       exp_q.push_back({b0v, cur});
            default: exp_q.push_back({8'h00, cur});
          endcase
        end
      end
    end
    tick();
    i_href = 1'b0;
    i_full = 1'b0;
    i_ovf_clr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_body(input int w, input int h);
    for (int y = 0; y < h; y++) send_line(y, w, 1'b1, -1);
  endtask

  task automatic do_vsync(input int m, input int x0, input int x1, input int y0, input int y1,
                          input int d, input int exp_frame, input int exp_drop);
    check("drain", exp_q.size(), 0);
    cur_mode = m; cx0 = x0; cx1 = x1; cy0 = y0; cy1 = y1; cd = d;
    kept_n = 0;
    dropped = 1'b0;
    i_mode = 2'(m);
    i_x0 = X_W'(x0); i_x1 = X_W'(x1);
    i_y0 = Y_W'(y0); i_y1 = Y_W'(y1);
    i_decim = 2'(d);
    tick();
    i_vsync = 1'b1;
    @(posedge i_pclk);
    @(negedge i_pclk);
    check("sof_pulse", o_sof, 1);
    check("frame_cnt", o_frame_cnt, exp_frame);
    check("drop_cnt", o_drop_cnt, exp_drop);
    @(negedge i_pclk);
    check("sof_one_cycle", o_sof, 0);
    tick();
    i_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"}, o_wr, 0);
    check({tag, "_wdata"}, o_wdata, 0);
    check({tag, "_sof"}, o_sof, 0);
    check({tag, "_ovf"}, o_ovf, 0);
    check({tag, "_frame"}, o_frame_cnt, 0);
    check({tag, "_drop"}, o_drop_cnt, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #1 i_rstn = 1'b0;
    repeat (3) @(posedge i_pclk);
    @(negedge i_pclk);
    check_all_zero("reset");
    tick();
    i_rstn = 1'b1;
    tick();
    i_cfg_done = 1'b1;
    repeat (2) tick();
    @(negedge i_pclk);
    check("busy_wait_sof", o_busy, 0);

    // RGB565 full window 16x8
    do_vsync(1, 0, 15, 0, 7, 0, 0, 0);
    check("busy_active", o_busy, 1);
    frame_body(16, 8);

    // RGB444 crop x 10..19, y 5..6 -> 20 writes
    do_vsync(0, 10, 19, 5, 6, 0, 1, 0);
    frame_body(24, 8);

    // Y from YUV422, decimate by 2 -> 8 writes
    do_vsync(2, 0, 7, 0, 3, 1, 2, 0);
    frame_body(8, 4);

    // raw bytes, x 3..5 on line 1 only
    do_vsync(3, 3, 5, 1, 1, 0, 3, 0);
    frame_body(8, 3);

    // overflow at 5th kept pixel, with simultaneous ovf clear
    do_vsync(1, 0, 7, 0, 3, 0, 4, 0);
    full_at = 5;
    frame_body(8, 4);
    full_at = 0;
    @(negedge i_pclk);
    check("ovf_set", o_ovf, 1);
    check("busy_drop", o_busy, 1);

    // inverted window: nothing written, frame still counts
    do_vsync(1, 5, 2, 0, 3, 0, 4, 1);
    check("ovf_sticky", o_ovf, 1);
    tick();
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    @(negedge i_pclk);
    check("ovf_clr", o_ovf, 0);
    frame_body(8, 4);

    // cfg_done drops mid-frame
    do_vsync(3, 0, 7, 0, 7, 0, 5, 1);
    send_line(0, 8, 1'b1, -1);
    send_line(1, 8, 1'b1, -1);
    i_cfg_done = 1'b0;
    @(negedge i_pclk);
    @(negedge i_pclk);
    check("busy_cfg_low", o_busy, 0);
    send_line(2, 8, 1'b0, -1);
    check("frame_cfg_low", o_frame_cnt, 5);
    check("drop_cfg_low", o_drop_cnt, 1);
    tick();
    i_cfg_done = 1'b1;
    tick();
    send_line(0, 8, 1'b0, -1);

    // first frame after re-enable does not finalise anything; reset mid-line
    do_vsync(3, 0, 7, 0, 7, 0, 5, 1);
    send_line(0, 8, 1'b1, -1);
    send_line(1, 8, 1'b1, 5);
    @(negedge i_pclk);
    check_all_zero("midrst");
    tick();
    i_rstn = 1'b1;
    tick();
    send_line(2, 8, 1'b0, -1);

    do_vsync(3, 0, 3, 0, 1, 0, 0, 0);
    frame_body(4, 2);
    do_vsync(3, 0, 3, 0, 1, 0, 1, 0);
    check("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
